// File: rtl/RS5_pkg.sv
// RS5_pkg: shared operation and store-FSM enums for the store unit.
package RS5_pkg;

    typedef enum logic [3:0] {NOP, LB, LBU, LH, LHU, LW, SB, SH, SW} iType_e;

    typedef enum logic [1:0] {IDLE, BEAT_LO, BEAT_HI, FINISH} store_state_e;

    function automatic logic is_store(iType_e op);
        return op inside {SB, SH, SW};
    endfunction

endpackage

// File: rtl/store_align.sv
// store_align: byte-lane strobe and data alignment for SB/SH/SW across a two-word window.
// data_hi exists only when MISALIGNED_SPLIT_EN is defined.
module store_align
    import RS5_pkg::*;
(
    input  iType_e      op,
    input  logic [1:0]  offset,
    input  logic [31:0] data,
    output logic [3:0]  strobe_lo,
    output logic [3:0]  strobe_hi,
`ifdef MISALIGNED_SPLIT_EN
    output logic [31:0] data_hi,
`endif
    output logic [31:0] data_lo
);

    logic [3:0] base;

    assign base = op == SB ? 4'b0001 : op == SH ? 4'b0011 : op == SW ? 4'b1111 : 4'b0000;
    assign {strobe_hi, strobe_lo} = {4'b0000, base} << offset;

`ifdef MISALIGNED_SPLIT_EN
    assign {data_hi, data_lo} = {32'b0, data} << {offset, 3'b000};
`else
    assign data_lo = data << {offset, 3'b000};
`endif

endmodule

// File: rtl/store_unit.sv
// store_unit: store FSM issuing one or two byte-strobed write beats per SB/SH/SW.
// MISALIGNED_SPLIT_EN enables two-beat misaligned stores; otherwise they are rejected.
module store_unit
    import RS5_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_i,
    input  iType_e      instruction_operation_i,
    input  logic [31:0] address_i,
    input  logic [31:0] data_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_address_o,
    output logic [3:0]  mem_write_enable_o,
    output logic [31:0] mem_data_o,
    output logic        done_o,
    output logic        misaligned_o
);

    store_state_e state, next_state;
    iType_e       op_q;
    logic [31:0]  addr_q, data_q, base, data_lo;
    logic [3:0]   strobe_lo, strobe_hi;
    logic         accept, misaligned;
`ifdef MISALIGNED_SPLIT_EN
    logic [31:0]  data_hi;
`endif

    store_align u_align (
        .op        (op_q),
        .offset    (addr_q[1:0]),
        .data      (data_q),
        .strobe_lo (strobe_lo),
        .strobe_hi (strobe_hi),
`ifdef MISALIGNED_SPLIT_EN
        .data_hi   (data_hi),
`endif
        .data_lo   (data_lo)
    );

    assign accept     = state == IDLE && valid_i && is_store(instruction_operation_i);
    assign misaligned = |strobe_hi;
    assign base       = {addr_q[31:2], 2'b00};
    assign busy_o     = ~ready_o;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            op_q   <= NOP;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_q   <= instruction_operation_i;
                addr_q <= address_i;
                data_q <= data_i;
            end
        end
    end

    // Beat fields are driven only while requesting, so idle outputs read as zero.
    always_comb begin
        next_state         = state;
        ready_o            = state == IDLE;
        mem_req_o          = 1'b0;
        mem_address_o      = '0;
        mem_write_enable_o = '0;
        mem_data_o         = '0;
        done_o             = 1'b0;
        misaligned_o       = 1'b0;
        case (state)
            IDLE: next_state = accept ? BEAT_LO : IDLE;
`ifdef MISALIGNED_SPLIT_EN
            BEAT_LO: begin
                mem_req_o          = 1'b1;
                mem_address_o      = base;
                mem_write_enable_o = strobe_lo;
                mem_data_o         = data_lo;
                if (mem_gnt_i) next_state = misaligned ? BEAT_HI : FINISH;
            end
            BEAT_HI: begin
                mem_req_o          = 1'b1;
                mem_address_o      = base + 32'd4;
                mem_write_enable_o = strobe_hi;
                mem_data_o         = data_hi;
                if (mem_gnt_i) next_state = FINISH;
            end
`else
            BEAT_LO: begin
                if (misaligned) begin
                    misaligned_o = 1'b1;
                    next_state   = IDLE;
                end else begin
                    mem_req_o          = 1'b1;
                    mem_address_o      = base;
                    mem_write_enable_o = strobe_lo;
                    mem_data_o         = data_lo;
                    if (mem_gnt_i) next_state = FINISH;
                end
            end
`endif
            FINISH: begin
                done_o     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: scoreboard bench for store_unit; expected beats and done/misaligned events are queued at issue.
module tb_store_unit;
    import RS5_pkg::*;

    logic        clk = 0, reset_n = 1, valid_i = 0, mem_gnt_i = 0;
    iType_e      op_i = NOP;
    logic [31:0] addr_i = 0, data_i = 0;
    logic        ready_o, busy_o, mem_req_o, done_o, misaligned_o;
    logic [31:0] mem_address_o, mem_data_o;
    logic [3:0]  mem_write_enable_o;

    typedef struct {logic [31:0] a; logic [3:0] s; logic [31:0] d;} beat_t;
    typedef struct {bit mis; int cyc;} evt_t;

    beat_t beat_q[$];
    evt_t  evt_q[$];
    beat_t b;
    evt_t  e;
    int    checks = 0, errors = 0, cyc = 0, waits_cfg = 0, wcnt = 0;
    logic        prev_req = 0, prev_gnt = 0;
    logic [31:0] prev_a = 0, prev_d = 0;
    logic [3:0]  prev_s = 0;

    store_unit dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .valid_i                 (valid_i),
        .instruction_operation_i (op_i),
        .address_i               (addr_i),
        .data_i                  (data_i),
        .ready_o                 (ready_o),
        .busy_o                  (busy_o),
        .mem_req_o               (mem_req_o),
        .mem_gnt_i               (mem_gnt_i),
        .mem_address_o           (mem_address_o),
        .mem_write_enable_o      (mem_write_enable_o),
        .mem_data_o              (mem_data_o),
        .done_o                  (done_o),
        .misaligned_o            (misaligned_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory model: grants each beat after waits_cfg wait states.
    always @(posedge clk) begin
        #1;
        if (mem_req_o) begin
            if (wcnt > 0) begin
                mem_gnt_i = 0;
                wcnt--;
            end else begin
                mem_gnt_i = 1;
                wcnt = waits_cfg;
            end
        end else mem_gnt_i = 0;
    end

    always @(negedge clk) begin
        chk("busy_vs_ready", busy_o, !ready_o);
        if (!mem_req_o) chk("idle_strobe", mem_write_enable_o, 0);
        if (mem_req_o && prev_req && !prev_gnt) begin
            chk("stall_addr", mem_address_o, prev_a);
            chk("stall_strobe", mem_write_enable_o, prev_s);
            chk("stall_data", mem_data_o, prev_d);
        end
        if (mem_req_o && mem_gnt_i) begin
            if (beat_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat addr=%h strobe=%b", mem_address_o, mem_write_enable_o);
            end else begin
                b = beat_q.pop_front();
                chk("beat_addr", mem_address_o, b.a);
                chk("beat_strobe", mem_write_enable_o, b.s);
                chk("beat_data", mem_data_o, b.d);
            end
        end
        if (done_o || misaligned_o) begin
            if (evt_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event done=%b misaligned=%b cycle=%0d", done_o, misaligned_o, cyc);
            end else begin
                e = evt_q.pop_front();
                chk("event_kind", misaligned_o, e.mis);
                chk("event_cycle", cyc, e.cyc);
            end
        end
        prev_req = mem_req_o;
        prev_gnt = mem_gnt_i;
        prev_a   = mem_address_o;
        prev_s   = mem_write_enable_o;
        prev_d   = mem_data_o;
    end

    // Called at a negedge; returns at a negedge with the unit idle again.
    task automatic issue(iType_e op, logic [31:0] a, logic [31:0] d, int w, int nbeats, bit mis);
        int t;
        t = 0;
        while (!ready_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("ready_before_issue", ready_o, 1);
        waits_cfg = w;
        wcnt = w;
        op_i = op;
        addr_i = a;
        data_i = d;
        valid_i = 1;
        evt_q.push_back('{mis, mis ? cyc + 1 : cyc + nbeats * (w + 1) + 1});
        @(negedge clk);
        valid_i = 0;
        chk("accepted_busy", ready_o, 0);
        if (mis) begin
            @(negedge clk);
            chk("mis_ready_back", ready_o, 1);
        end else begin
            t = 0;
            while (!ready_o && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk("done_ready_back", ready_o, 1);
        end
    endtask

    initial begin
        #1 reset_n = 0;
        #1;
        chk("rst_ready", ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_req", mem_req_o, 0);
        chk("rst_strobe", mem_write_enable_o, 0);
        chk("rst_addr", mem_address_o, 0);
        chk("rst_data", mem_data_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_mis", misaligned_o, 0);
        #10 reset_n = 1;
        @(negedge clk);

        beat_q.push_back('{32'h0000_0100, 4'b1000, 32'hDD00_0000});
        issue(SB, 32'h0000_0103, 32'hAABB_CCDD, 0, 1, 0);
        beat_q.push_back('{32'h0000_0200, 4'b1111, 32'hCAFE_F00D});
        issue(SW, 32'h0000_0200, 32'hCAFE_F00D, 3, 1, 0);
        beat_q.push_back('{32'h0000_0100, 4'b1100, 32'hABCD_0000});
        issue(SH, 32'h0000_0102, 32'h1234_ABCD, 1, 1, 0);
        beat_q.push_back('{32'h0000_0000, 4'b0010, 32'h0000_A500});
        issue(SB, 32'h0000_0001, 32'h0000_00A5, 0, 1, 0);
        beat_q.push_back('{32'h0000_0000, 4'b0011, 32'h0000_5A5A});
        issue(SH, 32'h0000_0000, 32'h0000_5A5A, 0, 1, 0);
`ifdef MISALIGNED_SPLIT_EN
        beat_q.push_back('{32'h0000_0200, 4'b1100, 32'h3344_0000});
        beat_q.push_back('{32'h0000_0204, 4'b0011, 32'h0000_1122});
        issue(SW, 32'h0000_0202, 32'h1122_3344, 0, 2, 0);
        beat_q.push_back('{32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000});
        beat_q.push_back('{32'h0000_0000, 4'b0001, 32'h0000_00BE});
        issue(SH, 32'hFFFF_FFFF, 32'h0000_BEEF, 0, 2, 0);
        beat_q.push_back('{32'h0000_0200, 4'b1000, 32'hEF00_0000});
        beat_q.push_back('{32'h0000_0204, 4'b0111, 32'h00DE_ADBE});
        issue(SW, 32'h0000_0203, 32'hDEAD_BEEF, 1, 2, 0);
`else
        issue(SH, 32'h0000_0003, 32'h0000_BEEF, 0, 0, 1);
        issue(SW, 32'h0000_0201, 32'h1122_3344, 0, 0, 1);
`endif

        op_i = LB;
        addr_i = 32'h0000_0100;
        valid_i = 1;
        repeat (3) begin
            @(negedge clk);
            chk("load_ignored_ready", ready_o, 1);
            chk("load_ignored_req", mem_req_o, 0);
        end
        valid_i = 0;

        waits_cfg = 1000;
        wcnt = 1000;
        op_i = SW;
        addr_i = 32'h0000_0300;
        data_i = 32'h5555_AAAA;
        valid_i = 1;
        @(negedge clk);
        valid_i = 0;
        chk("abort_req_before", mem_req_o, 1);
        #1 reset_n = 0;
        #1;
        chk("abort_req", mem_req_o, 0);
        chk("abort_ready", ready_o, 1);
        chk("abort_busy", busy_o, 0);
        chk("abort_strobe", mem_write_enable_o, 0);
        chk("abort_addr", mem_address_o, 0);
        chk("abort_data", mem_data_o, 0);
        chk("abort_done", done_o, 0);
        @(negedge clk);
        reset_n = 1;
        waits_cfg = 0;
        wcnt = 0;
        @(negedge clk);

        beat_q.push_back('{32'h0000_0010, 4'b1111, 32'h0102_0304});
        issue(SW, 32'h0000_0010, 32'h0102_0304, 0, 1, 0);

        repeat (3) @(negedge clk);
        chk("beats_left", beat_q.size(), 0);
        chk("events_left", evt_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 Parameters: none; all widths SHALL be fixed at 32-bit data/address and 4 byte lanes.
REQ-002 clk  in  1  core clock; all state SHALL update on the rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 valid_i  in  1  execute stage presents a memory operation this cycle.
REQ-005 instruction_operation_i  in  iType_e  operation; only SB, SH and SW SHALL be acted on.
REQ-006 address_i  in  32  effective byte address.
REQ-007 data_i  in  32  store data (rs2 value).
REQ-008 ready_o  out  1  unit idle and able to accept a store.
REQ-009 busy_o  out  1  stall request to the pipeline; equals NOT ready_o.
REQ-010 mem_req_o  out  1  write request to memory.
REQ-011 mem_gnt_i  in  1  memory accepts the beat in any cycle where mem_req_o=1 and mem_gnt_i=1.
REQ-012 mem_address_o  out  32  word-aligned beat address (bits [1:0] always 0).
REQ-013 mem_write_enable_o  out  4  byte-lane strobe of the current beat.
REQ-014 mem_data_o  out  32  lane-aligned write data.
REQ-015 done_o  out  1  single-cycle pulse when a store completes.
REQ-016 misaligned_o  out  1  single-cycle pulse for a rejected misaligned store.

Function
REQ-017 FSM states SHALL be IDLE, BEAT_LO, BEAT_HI, FINISH; ready_o=1 only in IDLE.
REQ-018 In IDLE, valid_i=1 with SB/SH/SW SHALL latch operation, address and data and leave IDLE on the next edge; any other operation SHALL be ignored.
REQ-019 Lane math: k=address[1:0]; 8-bit mask = 0001 (SB), 0011 (SH) or 1111 (SW), shifted left by k; 64-bit data = zero-extended data_i shifted left by 8*k.
REQ-020 Low beat: address {addr[31:2],00}, strobe mask[3:0], data data64[31:0].
REQ-021 High beat: address {addr[31:2],00}+4 with 32-bit wrap (0xFFFF_FFFC -> 0x0000_0000), strobe mask[7:4], data data64[63:32].
REQ-022 A store SHALL be misaligned when mask[7:4] is non-zero.
REQ-023 BEAT_LO/BEAT_HI SHALL hold mem_req_o=1 with stable address/strobe/data until granted; wait states are unbounded.
REQ-024 Grant in BEAT_LO: go to BEAT_HI if split is required, otherwise to FINISH; grant in BEAT_HI: go to FINISH.
REQ-025 FINISH SHALL assert done_o=1 for exactly one cycle, then return to IDLE; latency from acceptance to done_o is beats+waits+1 cycles.
REQ-026 mem_req_o SHALL be 0 in IDLE and FINISH; strobe SHALL be 0 whenever mem_req_o=0.
REQ-027 valid_i SHALL be ignored while not in IDLE; a new store is accepted in the cycle after done_o.

Reset
REQ-028 reset_n=0 SHALL asynchronously force IDLE, ready_o=1, busy_o=0, mem_req_o=0, strobe=0, mem_address_o=0, mem_data_o=0, done_o=0, misaligned_o=0.
REQ-029 Reset during a beat SHALL abandon it immediately with no done_o; an already granted low beat is not undone.

Configuration
REQ-030 Macro MISALIGNED_SPLIT_EN defined: misaligned SH/SW SHALL execute as two beats (BEAT_LO then BEAT_HI).
REQ-031 Macro undefined: BEAT_HI is not built; a misaligned store SHALL issue no mem_req_o, SHALL pulse misaligned_o once in the cycle after acceptance, and SHALL return to IDLE without done_o.

Structure
REQ-032 The store FSM enum (store_state_e) SHALL live in RS5_pkg, alongside iType_e.
REQ-033 Lane/strobe generation SHALL be one combinational sub-module, store_align, instantiated once; the FSM stays in store_unit.

Verification
REQ-034 SB, addr 0x103, data 0xAABBCCDD, gnt immediate -> one beat: addr 0x100, strobe 1000, data[31:24]=0xDD; done_o two cycles after acceptance.
REQ-035 SW, addr 0x200, gnt held low for 3 cycles -> mem_req_o and all beat fields stable for 4 cycles; done_o one cycle after grant.
REQ-036 With split: SW, addr 0x202, data 0x11223344 -> beat 0x200 strobe 1100 data[31:16]=0x3344, then beat 0x204 strobe 0011 data[15:0]=0x1122, then done_o.
REQ-037 With split: SH, addr 0xFFFFFFFF, data 0xBEEF -> beats 0xFFFFFFFC strobe 1000 (0xEF) and 0x00000000 strobe 0001 (0xBE).
REQ-038 Without split: SH, addr 0x3 -> no mem_req_o, misaligned_o pulse, no done_o, ready_o back to 1 after 2 cycles.
REQ-039 reset_n low mid-BEAT_LO with gnt=0 -> mem_req_o drops same cycle; LB on valid_i in IDLE -> no activity.
